// File: rtl/cpu_ctrl_if.sv
// Control bundle between the instruction sequencer (master) and the accumulator datapath (slave).
interface cpu_ctrl_if #(
    parameter int PERF_W = 16
);
    logic [2:0]        opcode;
    logic              zero;
    logic              mem_ready;
    logic              resume;
    logic              sel;
    logic              rd;
    logic              ld_ir;
    logic              inc_pc;
    logic              ld_pc;
    logic              ld_ac;
    logic              data_e;
    logic              wr;
    logic              halt;
    logic              err;
    logic [3:0]        phase;
    logic [PERF_W-1:0] instr_cnt;

    modport master (
        input  opcode, zero, mem_ready, resume,
        output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt, err, phase, instr_cnt
    );

    modport slave (
        output opcode, zero, mem_ready, resume,
        input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt, err, phase, instr_cnt
    );
endinterface

// File: rtl/cpu_ctrl_seq.sv
// 8-phase fetch/execute sequencer with memory-ready stalls, fetch watchdog and resumable halt.
// Optional completed-instruction counter enabled by defining CTRL_PERF_CNT_EN.
module cpu_ctrl_seq #(
    parameter int WAIT_MAX = 15,
    parameter int PERF_W   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    cpu_ctrl_if.master bus
);
    localparam logic [3:0] INST_ADDR  = 4'd0;
    localparam logic [3:0] INST_FETCH = 4'd1;
    localparam logic [3:0] INST_LOAD  = 4'd2;
    localparam logic [3:0] IDLE       = 4'd3;
    localparam logic [3:0] OP_ADDR    = 4'd4;
    localparam logic [3:0] OP_FETCH   = 4'd5;
    localparam logic [3:0] ALU_OP     = 4'd6;
    localparam logic [3:0] STORE      = 4'd7;
    localparam logic [3:0] HALTED     = 4'd8;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    localparam int WCW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    logic [3:0]     phase_q, phase_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic           err_q, err_d;
    logic           stall;
    logic           aluop, is_hlt, is_skz, is_sto, is_jmp;

    assign aluop  = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                    (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);
    assign is_hlt = (bus.opcode == OP_HLT);
    assign is_skz = (bus.opcode == OP_SKZ);
    assign is_sto = (bus.opcode == OP_STO);
    assign is_jmp = (bus.opcode == OP_JMP);

    always_comb begin
        phase_d = phase_q;
        wait_d  = wait_q;
        err_d   = err_q;
        stall   = 1'b0;
        case (phase_q)
            INST_ADDR:  phase_d = INST_FETCH;
            INST_FETCH: if (bus.mem_ready) phase_d = INST_LOAD; else stall = 1'b1;
            INST_LOAD:  phase_d = IDLE;
            IDLE:       phase_d = OP_ADDR;
            OP_ADDR:    phase_d = is_hlt ? HALTED : OP_FETCH;
            OP_FETCH:   if (!aluop || bus.mem_ready) phase_d = ALU_OP; else stall = 1'b1;
            ALU_OP:     phase_d = STORE;
            STORE:      phase_d = INST_ADDR;
            HALTED:     if (bus.resume && !err_q) phase_d = INST_ADDR;
            default:    phase_d = INST_ADDR;
        endcase
        // Watchdog trips on the cycle the wait count would reach WAIT_MAX.
        if (stall && WAIT_MAX != 0) begin
            if (int'(wait_q) >= WAIT_MAX - 1) begin
                err_d   = 1'b1;
                phase_d = HALTED;
            end else begin
                wait_d = wait_q + WCW'(1);
            end
        end
        if (phase_d != phase_q) wait_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= INST_ADDR;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        bus.sel    = 1'b0;
        bus.rd     = 1'b0;
        bus.ld_ir  = 1'b0;
        bus.inc_pc = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.data_e = 1'b0;
        bus.wr     = 1'b0;
        bus.halt   = 1'b0;
        case (phase_q)
            INST_ADDR:  bus.sel = 1'b1;
            INST_FETCH: begin bus.sel = 1'b1; bus.rd = 1'b1; end
            INST_LOAD, IDLE: begin
                bus.sel   = 1'b1;
                bus.rd    = 1'b1;
                bus.ld_ir = 1'b1;
            end
            OP_ADDR: begin
                bus.inc_pc = 1'b1;
                bus.halt   = is_hlt;
            end
            OP_FETCH: bus.rd = aluop;
            ALU_OP: begin
                bus.rd     = aluop;
                bus.inc_pc = is_skz && bus.zero;
                bus.ld_pc  = is_jmp;
                bus.data_e = is_sto;
            end
            STORE: begin
                bus.rd     = aluop;
                bus.ld_ac  = aluop;
                bus.inc_pc = is_jmp;
                bus.ld_pc  = is_jmp;
                bus.data_e = is_sto;
                bus.wr     = is_sto;
            end
            HALTED:  bus.halt = 1'b1;
            default: ;
        endcase
    end

    assign bus.err   = err_q;
    assign bus.phase = phase_q;

`ifdef CTRL_PERF_CNT_EN
    logic [PERF_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (phase_q == STORE && phase_d == INST_ADDR && cnt_q != '1)
            cnt_q <= cnt_q + PERF_W'(1);
    end

    assign bus.instr_cnt = cnt_q;
`else
    assign bus.instr_cnt = '0;
`endif
endmodule
